// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, zero-register constant and ID/EX pipeline register layout
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 8;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              reg_write;
        logic              is_load;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] imm;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: single-source operand selector with EX > MEM > WB > register-file priority
// addr: source register; rf_data: register file read data
// ex_*/mem_*/wb_*: in-flight producers; data: selected operand
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);
    // A load in EX has no data yet; the load-use bubble covers that case.
    always_comb
        data = (addr == ZERO_REG)                              ? '0 :
               (ex_reg_write && ex_rd == addr && !ex_is_load) ? ex_data :
               (mem_reg_write && mem_rd == addr)               ? mem_data :
               (wb_reg_write && wb_rd == addr)                 ? wb_data : rf_data;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID/EX operand fetch with forwarding, load-use bubble and ID/EX register
// id_*: decoded instruction; RA/RB, Bus_A/Bus_B: register file read port
// fwd_ex_*/fwd_mem_*/fwd_wb_*: forwarding sources; flush, ex_ready: pipeline control
// stall_out: hold IF/ID; idex_*: registered ID/EX outputs; bubble_count: saturating bubble tally
module operand_fetch_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CTRL_W = cpu_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_ready,
    output logic [ADDR_W-1:0] RA,
    output logic [ADDR_W-1:0] RB,
    input  logic [DATA_W-1:0] Bus_A,
    input  logic [DATA_W-1:0] Bus_B,
    input  logic [ADDR_W-1:0] fwd_ex_rd,
    input  logic              fwd_ex_reg_write,
    input  logic              fwd_ex_is_load,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic [ADDR_W-1:0] fwd_mem_rd,
    input  logic              fwd_mem_reg_write,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic [ADDR_W-1:0] fwd_wb_rd,
    input  logic              fwd_wb_reg_write,
    input  logic [DATA_W-1:0] fwd_wb_data,
    output logic              stall_out,
    output logic              idex_valid,
    output logic [ADDR_W-1:0] idex_rd,
    output logic              idex_reg_write,
    output logic              idex_is_load,
    output logic [DATA_W-1:0] idex_op_a,
    output logic [DATA_W-1:0] idex_op_b,
    output logic [DATA_W-1:0] idex_imm,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [CNT_W-1:0]  bubble_count
);
    import cpu_pkg::*;
    idex_t idex_q;
    logic [DATA_W-1:0] op_a, op_b;
    logic lu, hold;
    assign RA = id_rs1;
    assign RB = id_rs2;
    fwd_mux u_fwd_a (
        .addr(id_rs1), .rf_data(Bus_A),
        .ex_rd(fwd_ex_rd), .ex_reg_write(fwd_ex_reg_write), .ex_is_load(fwd_ex_is_load), .ex_data(fwd_ex_data),
        .mem_rd(fwd_mem_rd), .mem_reg_write(fwd_mem_reg_write), .mem_data(fwd_mem_data),
        .wb_rd(fwd_wb_rd), .wb_reg_write(fwd_wb_reg_write), .wb_data(fwd_wb_data),
        .data(op_a)
    );
    fwd_mux u_fwd_b (
        .addr(id_rs2), .rf_data(Bus_B),
        .ex_rd(fwd_ex_rd), .ex_reg_write(fwd_ex_reg_write), .ex_is_load(fwd_ex_is_load), .ex_data(fwd_ex_data),
        .mem_rd(fwd_mem_rd), .mem_reg_write(fwd_mem_reg_write), .mem_data(fwd_mem_data),
        .wb_rd(fwd_wb_rd), .wb_reg_write(fwd_wb_reg_write), .wb_data(fwd_wb_data),
        .data(op_b)
    );
    assign lu = id_valid && fwd_ex_reg_write && fwd_ex_is_load && fwd_ex_rd != ZERO_REG &&
                ((id_use_rs1 && id_rs1 == fwd_ex_rd) || (id_use_rs2 && id_rs2 == fwd_ex_rd));
    assign hold = idex_q.valid && !ex_ready;
    assign stall_out = (lu || hold) && !flush;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q       <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            idex_q.valid <= 1'b0;
        end else if (!hold) begin
            if (lu) begin
                idex_q.valid <= 1'b0;
                bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, ~&bubble_count};
            end else begin
                idex_q <= '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load,
                            op_a: op_a, op_b: op_b, imm: id_imm, ctrl: id_ctrl};
            end
        end
    end
    assign idex_valid     = idex_q.valid;
    assign idex_rd        = idex_q.rd;
    assign idex_reg_write = idex_q.reg_write;
    assign idex_is_load   = idex_q.is_load;
    assign idex_op_a      = idex_q.op_a;
    assign idex_op_b      = idex_q.op_b;
    assign idex_imm       = idex_q.imm;
    assign idex_ctrl      = idex_q.ctrl;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: vector table, corner-case sequences and random run against a reference model
module tb_operand_fetch_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;
    localparam int NW = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, flush, ex_ready;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, RA, RB, fwd_ex_rd, fwd_mem_rd, fwd_wb_rd, idex_rd;
    logic [DW-1:0] id_imm, Bus_A, Bus_B, fwd_ex_data, fwd_mem_data, fwd_wb_data;
    logic [DW-1:0] idex_op_a, idex_op_b, idex_imm;
    logic [CW-1:0] id_ctrl, idex_ctrl;
    logic fwd_ex_reg_write, fwd_ex_is_load, fwd_mem_reg_write, fwd_wb_reg_write;
    logic stall_out, idex_valid, idex_reg_write, idex_is_load;
    logic [NW-1:0] bubble_count;
    always #5 clk = ~clk;
    operand_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .ex_ready(ex_ready), .RA(RA), .RB(RB),
        .Bus_A(Bus_A), .Bus_B(Bus_B), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_reg_write(fwd_ex_reg_write),
        .fwd_ex_is_load(fwd_ex_is_load), .fwd_ex_data(fwd_ex_data), .fwd_mem_rd(fwd_mem_rd),
        .fwd_mem_reg_write(fwd_mem_reg_write), .fwd_mem_data(fwd_mem_data), .fwd_wb_rd(fwd_wb_rd),
        .fwd_wb_reg_write(fwd_wb_reg_write), .fwd_wb_data(fwd_wb_data), .stall_out(stall_out),
        .idex_valid(idex_valid), .idex_rd(idex_rd), .idex_reg_write(idex_reg_write), .idex_is_load(idex_is_load),
        .idex_op_a(idex_op_a), .idex_op_b(idex_op_b), .idex_imm(idex_imm), .idex_ctrl(idex_ctrl),
        .bubble_count(bubble_count)
    );
    int n_vec = 0;
    int n_bad = 0;
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic set_fwd(input logic [AW-1:0] erd, input logic ewe, input logic eld, input logic [DW-1:0] ed,
                           input logic [AW-1:0] mrd, input logic mwe, input logic [DW-1:0] md,
                           input logic [AW-1:0] wrd, input logic wwe, input logic [DW-1:0] wd);
        fwd_ex_rd = erd; fwd_ex_reg_write = ewe; fwd_ex_is_load = eld; fwd_ex_data = ed;
        fwd_mem_rd = mrd; fwd_mem_reg_write = mwe; fwd_mem_data = md;
        fwd_wb_rd = wrd; fwd_wb_reg_write = wwe; fwd_wb_data = wd;
    endtask
    task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic u1, input logic [AW-1:0] rs2,
                          input logic u2, input logic [AW-1:0] rd, input logic [DW-1:0] imm);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2; id_rd = rd;
        id_reg_write = 1'b1; id_is_load = 1'b0; id_imm = imm; id_ctrl = imm[CW-1:0];
    endtask
    // Reference: first producer in program-order-nearest list that writes addr wins; r0 is hardwired zero.
    function automatic logic [DW-1:0] ref_op(input logic [AW-1:0] a, input logic [DW-1:0] rf);
        logic [AW-1:0] rd [3];
        logic          wr [3];
        logic [DW-1:0] d  [3];
        rd = '{fwd_ex_rd, fwd_mem_rd, fwd_wb_rd};
        wr = '{fwd_ex_reg_write && !fwd_ex_is_load, fwd_mem_reg_write, fwd_wb_reg_write};
        d  = '{fwd_ex_data, fwd_mem_data, fwd_wb_data};
        if (a == 0) return '0;
        for (int i = 0; i < 3; i++) if (wr[i] && rd[i] == a) return d[i];
        return rf;
    endfunction
    function automatic logic ref_lu();
        return id_valid && fwd_ex_reg_write && fwd_ex_is_load && fwd_ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == fwd_ex_rd) || (id_use_rs2 && id_rs2 == fwd_ex_rd));
    endfunction
    typedef struct {
        logic [AW-1:0] rs1, rs2;
        logic [DW-1:0] bus_a, bus_b;
        logic [AW-1:0] ex_rd;
        logic          ex_we, ex_ld;
        logic [DW-1:0] ex_d;
        logic [AW-1:0] mem_rd;
        logic          mem_we;
        logic [DW-1:0] mem_d;
        logic [AW-1:0] wb_rd;
        logic          wb_we;
        logic [DW-1:0] wb_d, exp_a, exp_b;
    } vec_t;
    vec_t tbl [9];
    logic          m_valid, m_rd_we, m_ld;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_a, m_b, m_imm;
    logic [CW-1:0] m_ctrl;
    logic [NW-1:0] m_cnt;
    logic          e_lu, e_hold;
    initial begin
        tbl[0] = '{3, 4, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h11, 'h22};
        tbl[1] = '{3, 3, 'h11, 'h11, 3, 1, 0, 'hAA, 3, 1, 'hBB, 3, 1, 'hCC, 'hAA, 'hAA};
        tbl[2] = '{3, 3, 'h11, 'h11, 3, 0, 0, 'hAA, 3, 1, 'hBB, 3, 1, 'hCC, 'hBB, 'hBB};
        tbl[3] = '{3, 3, 'h11, 'h11, 3, 0, 0, 'hAA, 3, 0, 'hBB, 3, 1, 'hCC, 'hCC, 'hCC};
        tbl[4] = '{0, 0, 'h1234, 'h5678, 0, 1, 0, 'hFFFF, 0, 1, 'hBB, 0, 1, 'hCC, 0, 0};
        tbl[5] = '{3, 3, 'h11, 'h11, 3, 1, 1, 'hAA, 3, 1, 'hBB, 0, 0, 0, 'hBB, 'hBB};
        tbl[6] = '{7, 9, 'h70, 'h90, 9, 1, 0, 'hE9, 7, 1, 'hD7, 9, 1, 'hC9, 'hD7, 'hE9};
        tbl[7] = '{5, 5, 'h50, 'h50, 6, 1, 0, 'hE6, 4, 1, 'hD4, 5, 1, 'hCC, 'hCC, 'hCC};
        tbl[8] = '{4, 4, 'h40, 'h41, 3, 1, 0, 'hAA, 3, 1, 'hBB, 3, 1, 'hCC, 'h40, 'h41};
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 0, 0, 0);
        Bus_A = '0; Bus_B = '0; flush = 0; ex_ready = 1;
        #12;
        check("reset_valid", idex_valid, 0);
        check("reset_payload", {idex_rd, idex_reg_write, idex_op_a, idex_op_b, idex_imm, idex_ctrl}, 0);
        check("reset_count", bubble_count, 0);
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 9; i++) begin
            set_fwd(tbl[i].ex_rd, tbl[i].ex_we, tbl[i].ex_ld, tbl[i].ex_d, tbl[i].mem_rd, tbl[i].mem_we,
                    tbl[i].mem_d, tbl[i].wb_rd, tbl[i].wb_we, tbl[i].wb_d);
            set_id(1, tbl[i].rs1, 0, tbl[i].rs2, 0, AW'(i + 1), DW'(i + 'h100));
            Bus_A = tbl[i].bus_a; Bus_B = tbl[i].bus_b;
            #1;
            check("tbl_ra_rb", {RA, RB}, {tbl[i].rs1, tbl[i].rs2});
            check("tbl_stall", stall_out, 0);
            tick;
            check("tbl_op_a", idex_op_a, tbl[i].exp_a);
            check("tbl_op_b", idex_op_b, tbl[i].exp_b);
            check("tbl_valid_rd_imm", {idex_valid, idex_rd, idex_imm}, {1'b1, AW'(i + 1), DW'(i + 'h100)});
        end
        set_fwd(5, 1, 1, 'hDEAD, 0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 5, 1, 8, 'h1);
        Bus_B = 'h1111;
        #1 check("lu_stall", stall_out, 1);
        tick;
        check("lu_bubble", {idex_valid, bubble_count}, {1'b0, 16'd1});
        set_fwd(0, 0, 0, 0, 5, 1, 'h5A5A, 0, 0, 0);
        #1 check("lu_resume_stall", stall_out, 0);
        tick;
        check("lu_mem_fwd", {idex_valid, idex_op_b}, {1'b1, 32'h5A5A});
        set_fwd(0, 1, 1, 'hFFFF, 0, 0, 0, 0, 0, 0);
        set_id(1, 0, 1, 0, 1, 2, 'h2);
        Bus_A = 'h1234;
        #1 check("r0_load_no_stall", stall_out, 0);
        tick;
        check("r0_zero", {idex_valid, idex_op_a, bubble_count}, {1'b1, 32'h0, 16'd1});
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_id(1, 2, 1, 6, 1, 7, 'h44);
        Bus_A = 'h1111; Bus_B = 'h2222;
        tick;
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_id(1, AW'(i + 10), 1, AW'(i + 20), 1, AW'(i + 1), $urandom);
            Bus_A = $urandom; Bus_B = $urandom;
            #1 check("hold_stall", stall_out, 1);
            tick;
            check("hold_stable", {idex_valid, idex_rd, idex_op_a, idex_op_b, idex_imm, idex_ctrl},
                  {1'b1, 5'd7, 32'h1111, 32'h2222, 32'h44, 8'h44});
        end
        ex_ready = 1;
        set_id(1, 2, 1, 6, 1, 9, 'h55);
        Bus_A = 'h9999;
        #1 check("hold_release_stall", stall_out, 0);
        tick;
        check("hold_release", {idex_rd, idex_op_a}, {5'd9, 32'h9999});
        set_fwd(5, 1, 1, 'hDEAD, 0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 5, 1, 3, 0);
        flush = 1;
        #1 check("flush_lu_stall", stall_out, 0);
        tick;
        check("flush_lu", {idex_valid, bubble_count}, {1'b0, 16'd1});
        flush = 0;
        #1 check("lu_after_flush_stall", stall_out, 1);
        rst_n = 0;
        #1;
        check("rst_mid_stall", {idex_valid, idex_rd, idex_op_a, idex_op_b, idex_imm, idex_ctrl, bubble_count}, 0);
        #1 rst_n = 1;
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_id(1, 2, 1, 6, 0, 4, 'h66);
        Bus_A = 'h77;
        tick;
        check("post_reset_first", {idex_valid, idex_op_a}, {1'b1, 32'h77});
        ex_ready = 0;
        set_fwd(5, 1, 1, 'hDEAD, 0, 0, 0, 0, 0, 0);
        set_id(1, 5, 1, 0, 0, 1, 0);
        #1 check("hold_lu_stall", stall_out, 1);
        tick;
        check("hold_lu", {idex_valid, idex_op_a, bubble_count}, {1'b1, 32'h77, 16'd0});
        ex_ready = 1;
        repeat (65540) tick;
        check("count_saturate", {stall_out, bubble_count}, {1'b1, 16'hFFFF});
        rst_n = 0;
        #1 rst_n = 1;
        {m_valid, m_rd_we, m_ld, m_rd, m_a, m_b, m_imm, m_ctrl, m_cnt} = '0;
        for (int n = 0; n < 3000; n++) begin
            set_fwd(AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom,
                    AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom,
                    AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom);
            set_id($urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, AW'($urandom), $urandom);
            id_reg_write = $urandom_range(0, 1) == 1; id_is_load = $urandom_range(0, 1) == 1;
            id_ctrl = CW'($urandom);
            Bus_A = $urandom; Bus_B = $urandom;
            flush = $urandom_range(0, 7) == 0;
            ex_ready = $urandom_range(0, 3) != 0;
            #1;
            e_lu = ref_lu();
            e_hold = m_valid && !ex_ready;
            check("rnd_stall", stall_out, (e_lu || e_hold) && !flush);
            if (flush) m_valid = 0;
            else if (e_hold) m_valid = m_valid;
            else if (e_lu) begin
                m_valid = 0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
            end else begin
                m_valid = id_valid; m_rd = id_rd; m_rd_we = id_reg_write; m_ld = id_is_load;
                m_a = ref_op(id_rs1, Bus_A); m_b = ref_op(id_rs2, Bus_B); m_imm = id_imm; m_ctrl = id_ctrl;
            end
            tick;
            check("rnd_valid_count", {idex_valid, bubble_count}, {m_valid, m_cnt});
            if (m_valid)
                check("rnd_payload", {idex_rd, idex_reg_write, idex_is_load, idex_op_a, idex_op_b, idex_imm, idex_ctrl},
                      {m_rd, m_rd_we, m_ld, m_a, m_b, m_imm, m_ctrl});
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
